// File: rtl/aes256_cbc_frame_tx_if.sv
// AXI-Stream bundle between the frame transmitter and the AES-256-CBC core.
// W is the tdata width; tkeep carries one bit per byte.
interface axis_if #(
   parameter int W = 8
) ();
   localparam int KW = (W / 8 > 0) ? W / 8 : 1;

   logic [W-1:0]  tdata;
   logic [KW-1:0] tkeep;
   logic          tlast;
   logic          tuser;
   logic          tvalid;
   logic          tready;

   modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/aes256_cbc_frame_tx.sv
// Serialises key, IV and text blocks into the AES-256-CBC core's AXIS frame (tuser=direction, tlast on final word).
// Define AES_FRAME_PREFETCH_EN to add a block holding register that removes the per-block load bubble.
module aes256_cbc_frame_tx #(
   parameter int M_AXIS_WIDTH     = 8,
   parameter int NUM_BLOCKS_WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        start_i,
   input  logic                        encrypt_i,
   input  logic [255:0]                key_i,
   input  logic [127:0]                iv_i,
   input  logic [NUM_BLOCKS_WIDTH-1:0] num_blocks_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        reject_o,
   input  logic [127:0]                block_data_i,
   input  logic                        block_valid_i,
   output logic                        block_ready_o,
   axis_if.master                      m_axis
);
   localparam int W         = M_AXIS_WIDTH;
   localparam int NBW       = NUM_BLOCKS_WIDTH;
   localparam int KW        = (W / 8 > 0) ? W / 8 : 1;
   localparam int KEY_WORDS = 256 / W;
   localparam int TXT_WORDS = 128 / W;
   localparam int WC_W      = ($clog2(KEY_WORDS) == 0) ? 1 : $clog2(KEY_WORDS);
   localparam logic [WC_W-1:0] KEY_LAST = WC_W'(KEY_WORDS - 1);
   localparam logic [WC_W-1:0] TXT_LAST = WC_W'(TXT_WORDS - 1);
   localparam logic [NBW-1:0]  NB_ONE   = NBW'(1);
   localparam bit              TXT_ONE  = (TXT_WORDS == 1);

   typedef enum logic [2:0] {ST_IDLE, ST_KEY, ST_IV, ST_LOAD, ST_TEXT} state_t;

   state_t          state_q;
   logic [WC_W-1:0] wcnt_q;
   logic [WC_W-1:0] wcnt_d;
   logic [NBW-1:0]  blocks_left_q;
   logic [255:0]    key_q;
   logic [127:0]    iv_q;
   logic [127:0]    blk_q;
   logic [W-1:0]    tdata_q;
   logic            tvalid_q;
   logic            tlast_q;
   logic            tuser_q;
   logic            busy_q;
   logic            done_q;
   logic            reject_q;
   logic            hs;
   logic            blk_hs;
   logic            next_blk;
   logic            nxt_last;

   assign wcnt_d = wcnt_q + 1'b1;
   assign hs     = tvalid_q & m_axis.tready;
   assign blk_hs = block_valid_i & block_ready_o;

   // End of the IV, or of a text block that is not the final one: the next text block must start.
   assign next_blk = hs && (wcnt_q == TXT_LAST) &&
                     ((state_q == ST_IV) || ((state_q == ST_TEXT) && (blocks_left_q != NB_ONE)));
   assign nxt_last = (state_q == ST_TEXT) ? ((blocks_left_q - NB_ONE) == NB_ONE)
                                          : (blocks_left_q == NB_ONE);

`ifdef AES_FRAME_PREFETCH_EN
   logic [127:0]   hold_q;
   logic           hold_full_q;
   logic [NBW-1:0] to_fetch_q;

   assign block_ready_o = (state_q == ST_LOAD) ||
                          (((state_q == ST_KEY) || (state_q == ST_IV) || (state_q == ST_TEXT)) &&
                           !hold_full_q && (to_fetch_q != '0));
`else
   assign block_ready_o = (state_q == ST_LOAD);
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= ST_IDLE;
         wcnt_q        <= '0;
         blocks_left_q <= '0;
         key_q         <= '0;
         iv_q          <= '0;
         blk_q         <= '0;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         tuser_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         reject_q      <= 1'b0;
`ifdef AES_FRAME_PREFETCH_EN
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         to_fetch_q    <= '0;
`endif
      end else begin
         done_q   <= 1'b0;
         reject_q <= 1'b0;
`ifdef AES_FRAME_PREFETCH_EN
         if (blk_hs) begin
            to_fetch_q <= to_fetch_q - NB_ONE;
            if (state_q != ST_LOAD) begin
               hold_q      <= block_data_i;
               hold_full_q <= 1'b1;
            end
         end
`endif
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  if (num_blocks_i != '0) begin
                     key_q         <= key_i;
                     iv_q          <= iv_i;
                     tuser_q       <= encrypt_i;
                     blocks_left_q <= num_blocks_i;
`ifdef AES_FRAME_PREFETCH_EN
                     to_fetch_q    <= num_blocks_i;
                     hold_full_q   <= 1'b0;
`endif
                     wcnt_q        <= '0;
                     tdata_q       <= key_i[W-1:0];
                     tvalid_q      <= 1'b1;
                     tlast_q       <= 1'b0;
                     busy_q        <= 1'b1;
                     state_q       <= ST_KEY;
                  end else begin
                     reject_q <= 1'b1;
                  end
               end
            end
            ST_KEY: begin
               if (hs) begin
                  if (wcnt_q == KEY_LAST) begin
                     wcnt_q  <= '0;
                     tdata_q <= iv_q[W-1:0];
                     state_q <= ST_IV;
                  end else begin
                     wcnt_q  <= wcnt_d;
                     tdata_q <= key_q[wcnt_d*W +: W];
                  end
               end
            end
            ST_IV: begin
               if (hs && (wcnt_q != TXT_LAST)) begin
                  wcnt_q  <= wcnt_d;
                  tdata_q <= iv_q[wcnt_d*W +: W];
               end
            end
            ST_LOAD: begin
               if (block_valid_i) begin
                  blk_q    <= block_data_i;
                  wcnt_q   <= '0;
                  tdata_q  <= block_data_i[W-1:0];
                  tvalid_q <= 1'b1;
                  tlast_q  <= TXT_ONE && (blocks_left_q == NB_ONE);
                  state_q  <= ST_TEXT;
               end
            end
            ST_TEXT: begin
               if (hs) begin
                  if (wcnt_q != TXT_LAST) begin
                     wcnt_q  <= wcnt_d;
                     tdata_q <= blk_q[wcnt_d*W +: W];
                     tlast_q <= (wcnt_d == TXT_LAST) && (blocks_left_q == NB_ONE);
                  end else if (blocks_left_q == NB_ONE) begin
                     wcnt_q   <= '0;
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (next_blk) begin
            wcnt_q <= '0;
            if (state_q == ST_TEXT) begin
               blocks_left_q <= blocks_left_q - NB_ONE;
            end
`ifdef AES_FRAME_PREFETCH_EN
            if (hold_full_q) begin
               blk_q       <= hold_q;
               hold_full_q <= 1'b0;
               tdata_q     <= hold_q[W-1:0];
               tvalid_q    <= 1'b1;
               tlast_q     <= TXT_ONE && nxt_last;
               state_q     <= ST_TEXT;
            end else if (blk_hs) begin
               // Block arrives on the very cycle it is needed: bypass the holding register.
               blk_q       <= block_data_i;
               hold_full_q <= 1'b0;
               tdata_q     <= block_data_i[W-1:0];
               tvalid_q    <= 1'b1;
               tlast_q     <= TXT_ONE && nxt_last;
               state_q     <= ST_TEXT;
            end else begin
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               state_q  <= ST_LOAD;
            end
`else
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= ST_LOAD;
`endif
         end
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign reject_o      = reject_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = {KW{tvalid_q}};
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = tuser_q;
   assign m_axis.tvalid = tvalid_q;

   logic unused_ok;
   assign unused_ok = nxt_last;
endmodule
